dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Two-port round-robin arbiter in front of a single-ported, word-wide data
// memory. Port 0 is the core MEM stage and port 1 is the debug/loader port.
// Partial writes are done as read-modify-write: the old word is captured,
// the enabled bytes are merged in, and the full word is written back.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   req0/req1             access requests (held stable until ack)
//   addr0/addr1           byte addresses; bits [1:0] are ignored
//   we0/we1               1 = write, 0 = read
//   be0/be1               write byte enables, bit i covers data[8i+7:8i]
//   wdata0/wdata1         write data
//   ack0/ack1             one-cycle completion pulse to the owning port
//   rdata                 read result, valid in the ack cycle, held otherwise
//   busy                  high whenever the FSM is not in IDLE
//   mem_addr              word address to the data memory
//   mem_we                memory write strobe (memory writes on rising edge)
//   mem_wdata             memory write word
//   mem_rdata             combinational memory read word for mem_addr
//   fsm_state             current FSM state, for debug and assertion binding
//
// Handshake: a port raises req with its fields and holds all of them stable
// until it sees its ack; it drops or renews req in the cycle after ack.
// Fields are only sampled in IDLE, so anything a port does while the block
// is busy has no effect on the access in flight.
module dmem_arbiter #(
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [MEM_AW-1:0]   addr_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         merge_q;
    logic                owner_q;
    logic                last_grant;

    logic                grant_valid;
    logic                grant_port;
    logic [31:0]         be_mask;
    logic                be_full;
    logic                be_none;

    // Round robin: on a tie the port that did not win last time goes.
    // last_grant resets to 1 so port 0 wins the first tie.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = req1;
        end
    end

    always_comb begin
        be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
        be_full = (be_q == 4'hF);
        be_none = (be_q == 4'h0);
    end

    // State register and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            rdata      <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_valid) begin
                owner_q    <= grant_port;
                last_grant <= grant_port;
                if (grant_port) begin
                    addr_q  <= addr1[MEM_AW+1:2];
                    we_q    <= we1;
                    be_q    <= be1;
                    wdata_q <= wdata1;
                end else begin
                    addr_q  <= addr0[MEM_AW+1:2];
                    we_q    <= we0;
                    be_q    <= be0;
                    wdata_q <= wdata0;
                end
            end
            if (state == ACCESS) begin
                if (!we_q) begin
                    rdata <= mem_rdata;
                end else if (!be_full && !be_none) begin
                    merge_q <= mem_rdata;
                end
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = (state != IDLE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;

        case (state)
            IDLE: begin
                mem_addr  = '0;
                mem_wdata = 32'h0;
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q || be_none) begin
                    state_nxt = DONE;
                end else if (be_full) begin
                    mem_we    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = MERGE;
                end
            end
            MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = (wdata_q & be_mask) | (merge_q & ~be_mask);
                state_nxt = DONE;
            end
            DONE: begin
                ack0      = ~owner_q;
                ack1      = owner_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fsm_state = state;

endmodule
